// File: rtl/mult_div_unit.sv
// mult_div_unit: sequential signed 32x32 multiply (radix-2 Booth) and
// restoring divide for the multicycle MIPS datapath. The results land in
// HI/LO 33 cycles after a one-cycle start pulse.
// Optional feature: define MULTDIV_DIVZERO_EN for early divide-by-zero
// detection with a div_zero pulse. When it is undefined, divide by zero
// runs the full sequence and forces LO=all ones, HI=dividend.
module mult_div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic        busy,
    output logic        done,
    output logic        div_zero
);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state_q, state_d;
    logic               op_q, op_d;
    logic signed [31:0] a_q, a_d;
    logic signed [31:0] b_q, b_d;
    logic        [4:0]  cnt_q, cnt_d;
    // MULT: {P_hi(33, sign-extended), P_lo(32), q-1}; DIV: [63:0] = {rem, quo}
    logic        [65:0] acc_q, acc_d;
    logic        [31:0] hi_q, hi_d;
    logic        [31:0] lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               dz_q, dz_d;

    // Magnitude of a signed word; 0x80000000 maps to 2^31 as an unsigned value.
    function automatic logic [31:0] abs32(input logic signed [31:0] v);
        return v[31] ? 32'(-v) : 32'(v);
    endfunction

    // One Booth step: add/subtract b based on {P[0], q-1}, then arithmetic shift.
    // The 33-bit upper half absorbs the +2^31 that arises from subtracting -2^31.
    function automatic logic [65:0] booth_step(input logic [65:0] acc,
                                               input logic signed [31:0] b);
        logic signed [32:0] hi;
        logic signed [32:0] bx;
        logic        [65:0] t;
        hi = acc[65:33];
        bx = {b[31], b};
        case (acc[1:0])
            2'b01:   hi = hi + bx;
            2'b10:   hi = hi - bx;
            default: hi = hi;
        endcase
        t = {hi, acc[32:0]};
        return {t[65], t[65:1]};
    endfunction

    // One restoring-division step on magnitudes: shift left, then trial subtract.
    function automatic logic [63:0] div_step(input logic [63:0] r,
                                             input logic [31:0] bmag);
        logic [63:0] s;
        logic [32:0] diff;
        s    = {r[62:0], 1'b0};
        diff = {1'b0, s[63:32]} - {1'b0, bmag};
        if (!diff[32]) begin
            s[63:32] = diff[31:0];
            s[0]     = 1'b1;
        end
        return s;
    endfunction

    // Apply signs: quotient negative when signs differ, remainder follows the dividend.
    function automatic logic [63:0] div_fix(input logic [31:0] rem,
                                            input logic [31:0] quo,
                                            input logic        sa,
                                            input logic        sb);
        logic [31:0] r;
        logic [31:0] q;
        r = sa ? 32'(-rem) : rem;
        q = (sa ^ sb) ? 32'(-quo) : quo;
        return {r, q};
    endfunction

    // Next-state and datapath logic for the IDLE/RUN/FIX sequencer.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dz_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d    = a_in;
                    b_d    = b_in;
                    op_d   = op;
                    cnt_d  = 5'd31;
                    busy_d = 1'b1;
                    acc_d  = op ? {34'd0, abs32(a_in)} : {33'd0, a_in, 1'b0};
                    state_d = RUN;
`ifdef MULTDIV_DIVZERO_EN
                    if (op && (b_in == 32'd0)) begin
                        state_d = FIX;
                    end
`endif
                end
            end
            RUN: begin
                acc_d = op_q ? {2'b00, div_step(acc_q[63:0], abs32(b_q))}
                             : booth_step(acc_q, b_q);
                if (cnt_q == 5'd0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            FIX: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                if (!op_q) begin
                    hi_d = acc_q[64:33];
                    lo_d = acc_q[32:1];
                end else if (b_q == 32'sd0) begin
`ifdef MULTDIV_DIVZERO_EN
                    dz_d = 1'b1;
`else
                    hi_d = a_q;
                    lo_d = 32'hFFFF_FFFF;
`endif
                end else begin
                    {hi_d, lo_d} = div_fix(acc_q[63:32], acc_q[31:0], a_q[31], b_q[31]);
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears everything and aborts any operation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    assign hi_out   = hi_q;
    assign lo_out   = lo_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = dz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus random
// operations compared against an arithmetic reference model.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        busy;
    logic        done;
    logic        div_zero;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_hi   = 32'd0;
    logic [31:0] exp_lo   = 32'd0;

`ifdef MULTDIV_DIVZERO_EN
    localparam bit DZ_EN = 1'b1;
`else
    localparam bit DZ_EN = 1'b0;
`endif

    mult_div_unit dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a_in     (a_in),
        .b_in     (b_in),
        .hi_out   (hi_out),
        .lo_out   (lo_out),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference result {HI, LO} from plain signed arithmetic.
    function automatic logic [63:0] model(input bit o, input logic [31:0] a, input logic [31:0] b);
        longint p;
        int     sa;
        int     sb;
        int     q;
        int     r;
        if (!o) begin
            p = longint'($signed(a)) * longint'($signed(b));
            return 64'(p);
        end
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        sa = a;
        sb = b;
        q  = sa / sb;
        r  = sa % sb;
        return {r, q};
    endfunction

    // Present a request at the current negedge; returns at the negedge after edge k.
    task automatic launch(input bit o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        a_in  = a;
        b_in  = b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        op    = 1'($urandom);
        a_in  = $urandom;
        b_in  = $urandom;
        chk("busy_after_start", 64'(busy), 64'd1);
        chk("done_after_start", 64'(done), 64'd0);
    endtask

    // Wait for done (bounded) and check latency, busy length and results.
    task automatic wait_done(input bit o, input logic [31:0] a, input logic [31:0] b, input bit inj);
        logic [63:0] m;
        int          lat;
        int          exp_lat;
        int          nbusy;
        bit          dz;
        dz      = DZ_EN && o && (b == 32'd0);
        exp_lat = dz ? 1 : 33;
        lat     = 0;
        nbusy   = 0;
        while (!done && lat < 40) begin
            if (busy) nbusy++;
            if (inj && lat == 5) begin
                start = 1'b1;
                op    = ~o;
                a_in  = $urandom;
                b_in  = $urandom;
            end else begin
                start = 1'b0;
            end
            if (lat == 20) begin
                chk("hold_hi", 64'(hi_out), 64'(exp_hi));
                chk("hold_lo", 64'(lo_out), 64'(exp_lo));
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        chk("latency", 64'(lat), 64'(exp_lat));
        chk("busy_cycles", 64'(nbusy), 64'(exp_lat));
        chk("busy_at_done", 64'(busy), 64'd0);
        chk("div_zero", 64'(div_zero), 64'(dz));
        if (!dz) begin
            m      = model(o, a, b);
            exp_hi = m[63:32];
            exp_lo = m[31:0];
        end
        chk("hi", 64'(hi_out), 64'(exp_hi));
        chk("lo", 64'(lo_out), 64'(exp_lo));
    endtask

    task automatic run_op(input bit o, input logic [31:0] a, input logic [31:0] b);
        launch(o, a, b);
        wait_done(o, a, b, 1'b0);
        @(negedge clk);
        chk("done_clears", 64'(done), 64'd0);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        bit          ro;
        int          ndone;

        reset = 1'b0;
        start = 1'b0;
        op    = 1'b0;
        a_in  = '0;
        b_in  = '0;
        #1 reset = 1'b1;
        #1;
        chk("rst_hi", 64'(hi_out), 64'd0);
        chk("rst_lo", 64'(lo_out), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_div_zero", 64'(div_zero), 64'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        run_op(1'b0, 32'd6, 32'd7);
        run_op(1'b0, 32'hFFFF_FFFD, 32'd5);
        run_op(1'b0, 32'h8000_0000, 32'h8000_0000);
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2);
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(1'b1, 32'd100, 32'd0);

        // Start during a busy MULT is ignored; start in the done cycle is accepted.
        launch(1'b0, 32'h1234_5678, 32'hFEDC_BA98);
        wait_done(1'b0, 32'h1234_5678, 32'hFEDC_BA98, 1'b1);
        launch(1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFD);
        wait_done(1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        @(negedge clk);
        chk("done_clears_chain", 64'(done), 64'd0);

        // Asynchronous reset in the middle of a DIV aborts it.
        launch(1'b1, 32'd1234567, 32'hFFFF_FFA7);
        repeat (9) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_hi", 64'(hi_out), 64'd0);
        chk("midrst_lo", 64'(lo_out), 64'd0);
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("midrst_no_done", 64'(ndone), 64'd0);

        for (int i = 0; i < 20; i++) begin
            ro = 1'($urandom);
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: ra = 32'h8000_0000;
                2: rb = 32'hFFFF_FFFF;
                3: rb = $urandom_range(0, 15);
                default: ;
            endcase
            run_op(ro, ra, rb);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
